// File: rtl/path_sequencer.sv
// path_sequencer: latches generated path groups on start and streams their 2-bit node IDs
// over a valid/ready handshake, in group order then index order, with a done pulse.
module path_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [1:0] group_i,
  input  logic [2:0] len_0_i,
  input  logic [1:0] len_1_i,
  input  logic [1:0] len_2_i,
  input  logic [7:0] data_0_i,
  input  logic [5:0] data_1_i,
  input  logic [3:0] data_2_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [1:0] out_node_o,
  output logic [1:0] out_grp_o,
  output logic [1:0] out_idx_o,
  output logic       out_last_grp_o,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] count_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_EMIT = 2'd1, S_DONE = 2'd2;
  logic [1:0] r_state, r_grp, r_idx, r_l1, r_l2;
  logic [2:0] r_l0;
  logic [7:0] r_d0;
  logic [5:0] r_d1;
  logic [3:0] r_d2;
  logic [3:0] r_cnt;
  logic [2:0] w_ld_l0, w_len;
  logic [1:0] w_ld_l1, w_ld_l2, w_ld_grp, w_next_grp, w_node;
  logic [7:0] w_data;
  logic       w_ld_any, w_emit, w_xfer, w_last_grp, w_later;
  // Lengths are clamped and masked by the group count once, at load time.
  assign w_ld_l0    = (group_i == 2'd0) ? 3'd0 : (len_0_i > 3'd4 ? 3'd4 : len_0_i);
  assign w_ld_l1    = (group_i >= 2'd2) ? len_1_i : 2'd0;
  assign w_ld_l2    = (group_i == 2'd3) ? (len_2_i == 2'd3 ? 2'd2 : len_2_i) : 2'd0;
  assign w_ld_any   = |{w_ld_l0, w_ld_l1, w_ld_l2};
  assign w_ld_grp   = (w_ld_l0 != 3'd0) ? 2'd0 : (w_ld_l1 != 2'd0) ? 2'd1 : 2'd2;
  assign w_emit     = (r_state == S_EMIT);
  assign w_xfer     = w_emit && out_ready_i;
  assign w_len      = (r_grp == 2'd0) ? r_l0 : (r_grp == 2'd1) ? {1'b0, r_l1} : {1'b0, r_l2};
  assign w_data     = (r_grp == 2'd0) ? r_d0 : (r_grp == 2'd1) ? {2'b00, r_d1} : {4'b0000, r_d2};
  assign w_node     = w_data[{r_idx, 1'b0} +: 2];
  assign w_last_grp = ({1'b0, r_idx} == w_len - 3'd1);
  assign w_later    = (r_grp == 2'd0) ? |{r_l1, r_l2} : (r_grp == 2'd1) ? |r_l2 : 1'b0;
  assign w_next_grp = (r_grp == 2'd0 && r_l1 != 2'd0) ? 2'd1 : 2'd2;
  assign out_valid_o    = w_emit;
  assign out_node_o     = w_emit ? w_node : 2'd0;
  assign out_grp_o      = w_emit ? r_grp : 2'd0;
  assign out_idx_o      = w_emit ? r_idx : 2'd0;
  assign out_last_grp_o = w_emit && w_last_grp;
  assign out_last_o     = w_emit && w_last_grp && !w_later;
  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = (r_state == S_DONE);
  assign count_o        = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grp   <= 2'd0;
      r_idx   <= 2'd0;
      r_l0    <= 3'd0;
      r_l1    <= 2'd0;
      r_l2    <= 2'd0;
      r_d0    <= 8'd0;
      r_d1    <= 6'd0;
      r_d2    <= 4'd0;
      r_cnt   <= 4'd0;
    end else if (r_state == S_IDLE && start_i) begin
      r_d0    <= data_0_i;
      r_d1    <= data_1_i;
      r_d2    <= data_2_i;
      r_l0    <= w_ld_l0;
      r_l1    <= w_ld_l1;
      r_l2    <= w_ld_l2;
      r_grp   <= w_ld_grp;
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
      r_state <= w_ld_any ? S_EMIT : S_DONE;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 4'd1;
      if (!w_last_grp) begin
        r_idx <= r_idx + 2'd1;
      end else begin
        r_idx <= 2'd0;
        r_grp <= w_next_grp;
        if (!w_later) r_state <= S_DONE;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_path_sequencer.sv
// tb_path_sequencer: checks path_sequencer against a queue-based model of the expected stream,
// plus literal expectations for the directed paths.
module tb_path_sequencer;
  logic       clk = 0, rst = 1, start_i = 0, out_ready_i = 0;
  logic [1:0] group_i = 0, len_1_i = 0, len_2_i = 0;
  logic [2:0] len_0_i = 0;
  logic [7:0] data_0_i = 0;
  logic [5:0] data_1_i = 0;
  logic [3:0] data_2_i = 0;
  logic       out_valid_o, out_last_grp_o, out_last_o, busy_o, done_o;
  logic [1:0] out_node_o, out_grp_o, out_idx_o;
  logic [3:0] count_o;
  int checks = 0, errors = 0;
  int n_done = 0, n_busy = 0, n_valid = 0;
  typedef logic [7:0] ent_t;
  ent_t q[$], cap[$], exp_q[$];
  logic       m_done = 0;
  logic [3:0] m_count = 0;

  path_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .group_i(group_i),
    .len_0_i(len_0_i), .len_1_i(len_1_i), .len_2_i(len_2_i),
    .data_0_i(data_0_i), .data_1_i(data_1_i), .data_2_i(data_2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_node_o(out_node_o),
    .out_grp_o(out_grp_o), .out_idx_o(out_idx_o), .out_last_grp_o(out_last_grp_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected stream as a list of entries {last_grp, last, grp, idx, node}.
  function automatic void build();
    int   l[3];
    logic [7:0] d[3];
    ent_t e;
    l[0] = group_i >= 2'd1 ? (len_0_i > 3'd4 ? 4 : int'(len_0_i)) : 0;
    l[1] = group_i >= 2'd2 ? int'(len_1_i) : 0;
    l[2] = group_i == 2'd3 ? (len_2_i > 2'd2 ? 2 : int'(len_2_i)) : 0;
    d[0] = data_0_i;
    d[1] = {2'b00, data_1_i};
    d[2] = {4'b0000, data_2_i};
    q.delete();
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < l[g]; i++)
        q.push_back({i == l[g] - 1, 1'b0, 2'(g), 2'(i), 2'((d[g] >> (2 * i)) & 8'd3)});
    if (q.size() != 0) begin
      e = q.pop_back();
      e[6] = 1'b1;
      q.push_back(e);
    end
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_done = 0;
      m_count = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (q.size() != 0) begin
      if (out_ready_i) begin
        void'(q.pop_front());
        m_count++;
        if (q.size() == 0) m_done = 1;
      end
    end else if (start_i) begin
      build();
      m_count = 0;
      m_done = (q.size() == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("valid", out_valid_o, q.size() != 0);
      chk("busy", busy_o, q.size() != 0 || m_done);
      chk("done", done_o, m_done);
      chk("count", count_o, m_count);
      if (q.size() != 0 && out_valid_o)
        chk("entry", {out_last_grp_o, out_last_o, out_grp_o, out_idx_o, out_node_o}, q[0]);
      if (out_valid_o && out_ready_i)
        cap.push_back({out_last_grp_o, out_last_o, out_grp_o, out_idx_o, out_node_o});
      n_done += int'(done_o);
      n_busy += int'(busy_o);
      n_valid += int'(out_valid_o);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] g, input logic [2:0] l0, input logic [1:0] l1, input logic [1:0] l2,
                        input logic [7:0] d0, input logic [5:0] d1, input logic [3:0] d2);
    group_i = g; len_0_i = l0; len_1_i = l1; len_2_i = l2;
    data_0_i = d0; data_1_i = d1; data_2_i = d2;
  endtask

  task automatic scramble;
    group_i = 2'($urandom); len_0_i = 3'($urandom); len_1_i = 2'($urandom); len_2_i = 2'($urandom);
    data_0_i = 8'($urandom); data_1_i = 6'($urandom); data_2_i = 4'($urandom);
  endtask

  task automatic run_path(input string nm, input int stall_at, input int stall_n, input logic [3:0] exp_cnt,
                          output int nb, output int nv);
    int bc, bd, bb, bv, st;
    bc = cap.size(); bd = n_done; bb = n_busy; bv = n_valid; st = 0;
    start_i = 1;
    out_ready_i = 1;
    tick;
    start_i = 0;
    scramble;
    for (int c = 0; c < 60 && n_done == bd; c++) begin
      if (cap.size() - bc == stall_at && st < stall_n) begin
        out_ready_i = 0;
        st++;
      end else out_ready_i = 1;
      scramble;
      tick;
    end
    chk({nm, " done pulses"}, n_done - bd, 1);
    chk({nm, " length"}, cap.size() - bc, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({nm, " stream"}, (bc + i < cap.size()) ? cap[bc + i] : 8'hFF, exp_q[i]);
    chk({nm, " final count"}, count_o, exp_cnt);
    tick;
    nb = n_busy - bb;
    nv = n_valid - bv;
  endtask

  initial begin
    int nb, nv, bc, bd;
    repeat (2) tick;
    chk("reset outputs", {out_valid_o, out_node_o, out_grp_o, out_idx_o, out_last_grp_o, out_last_o,
                          busy_o, done_o, count_o}, 0);
    rst = 0;
    tick;
    exp_q = '{8'h00, 8'h05, 8'h0A, 8'h8F, 8'h11, 8'hD6};
    set_in(2, 4, 2, 0, 8'b11100100, 6'b001001, 4'h0);
    run_path("grp2", -1, 0, 6, nb, nv);
    chk("grp2 busy cycles", nb, 7);
    chk("grp2 valid cycles", nv, 6);
    set_in(2, 4, 2, 0, 8'b11100100, 6'b001001, 4'h0);
    run_path("grp2 stall", 1, 3, 6, nb, nv);
    chk("grp2 stall valid cycles", nv, 9);
    exp_q = '{8'h00, 8'h05, 8'h0A, 8'h8F, 8'h21, 8'hE6};
    set_in(3, 7, 0, 2, 8'hE4, 6'h00, 4'b1001);
    run_path("grp3 clamp", -1, 0, 6, nb, nv);
    exp_q = '{8'hC3};
    set_in(1, 1, 3, 2, 8'h03, 6'h3F, 4'hF);
    run_path("grp1 mask", -1, 0, 1, nb, nv);
    exp_q = {};
    set_in(0, 4, 3, 2, 8'hFF, 6'h3F, 4'hF);
    run_path("zero path", -1, 0, 0, nb, nv);
    chk("zero path busy cycles", nb, 1);
    chk("zero path valid cycles", nv, 0);
    start_i = 1;
    for (int c = 0; c < 40; c++) begin
      out_ready_i = 1;
      scramble;
      tick;
    end
    start_i = 0;
    repeat (12) tick;
    bc = cap.size();
    set_in(2, 4, 2, 0, 8'b11100100, 6'b001001, 4'h0);
    start_i = 1;
    out_ready_i = 1;
    tick;
    start_i = 0;
    for (int c = 0; c < 20 && cap.size() - bc < 2; c++) tick;
    chk("pre-reset transfers", cap.size() - bc, 2);
    #2;
    rst = 1;
    #1;
    chk("async reset outputs", {out_valid_o, out_node_o, out_grp_o, out_idx_o, out_last_grp_o, out_last_o,
                                busy_o, done_o, count_o}, 0);
    bd = n_done;
    repeat (3) tick;
    chk("reset done_o", done_o, 0);
    rst = 0;
    tick;
    chk("no done after reset", n_done - bd, 0);
    exp_q = '{8'h00, 8'h05, 8'h0A, 8'h8F, 8'h11, 8'hD6};
    set_in(2, 4, 2, 0, 8'b11100100, 6'b001001, 4'h0);
    run_path("post-reset", -1, 0, 6, nb, nv);
    for (int c = 0; c < 3000; c++) begin
      scramble;
      start_i = ($urandom_range(0, 3) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      tick;
    end
    start_i = 0;
    out_ready_i = 1;
    repeat (15) tick;
    chk("end idle", busy_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/path_sequencer.md
# path_sequencer

Downstream stage of the path generator in the hypercube NoC. Latches one set of generated path groups on `start_i`. Serialises the groups into a stream of 2-bit node IDs, one per valid/ready transfer, in group order and index order. Reports completion so the router-side injector can request the next path.

## Interface
Parameters: none. All widths match the path generator outputs.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  load request; sampled only in IDLE
- `group_i`  in  2  number of groups in use (0..3)
- `len_0_i`  in  3  entry count for group 0
- `len_1_i`  in  2  entry count for group 1
- `len_2_i`  in  2  entry count for group 2
- `data_0_i`  in  8  group 0 node IDs; entry k = bits [2k+1:2k], k=0..3
- `data_1_i`  in  6  group 1 node IDs; entry k, k=0..2
- `data_2_i`  in  4  group 2 node IDs; entry k, k=0..1
- `out_valid_o`  out  1  an entry is presented
- `out_ready_i`  in  1  consumer accepts the entry
- `out_node_o`  out  2  node ID of the current entry
- `out_grp_o`  out  2  group of the current entry
- `out_idx_o`  out  2  index within the group
- `out_last_grp_o`  out  1  current entry is the last of its group
- `out_last_o`  out  1  current entry is the last of the whole path
- `busy_o`  out  1  high whenever the state is not IDLE
- `done_o`  out  1  one-cycle completion pulse
- `count_o`  out  4  entries transferred since the last accepted start

## Operation
- Effective lengths:
  - L0 = min(len_0, 4), L1 = min(len_1, 3), L2 = min(len_2, 2).
  - Any group k with k ≥ group_i has Lk forced to 0.
  - Total entries: 0..9.
- State machine: IDLE, EMIT, DONE.
  - IDLE, start_i=1: latch all inputs, clear count_o, set grp/idx to the first group with nonzero length.
    - If a nonzero group exists, go to EMIT. Otherwise go to DONE.
  - IDLE, start_i=0: stay.
  - EMIT: out_valid_o=1. out_node_o = latched data_g[2·idx+1 : 2·idx].
    - On a transfer (valid && ready): count_o += 1.
      - If idx < Lg−1: idx += 1.
      - Else advance to the next group with nonzero length, idx=0. Zero-length groups are skipped in the same cycle.
      - If no nonzero group remains, go to DONE.
  - DONE: done_o=1 for exactly this cycle, then go to IDLE.
- Flags: out_last_grp_o = (idx == Lg−1). out_last_o = out_last_grp_o && no later group has nonzero length.
- start_i outside IDLE is ignored. Latched values are immune to input changes after the load cycle.
- count_o holds its value after DONE until the next accepted start.

## Timing
- Reset values:
  - state = IDLE; out_valid_o = 0; out_node_o = 0; out_grp_o = 0; out_idx_o = 0.
  - out_last_grp_o = 0; out_last_o = 0; busy_o = 0; done_o = 0; count_o = 0.
- Start accepted at edge T: out_valid_o is high from T+1. Zero-length path: done_o is high in T+1 and the block is back in IDLE at T+2.
- Handshake:
  - While out_valid_o=1 and out_ready_i=0, all out_* signals hold stable.
  - At most one transfer per cycle. Full throughput: N entries occupy N consecutive cycles.
- The last transfer at edge T gives DONE, with done_o high and out_valid_o low, in T+1. A new start is accepted no earlier than the edge ending the T+2 cycle.
- Outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- rst asserted mid-path: all outputs go to reset values immediately (asynchronously). The path is discarded and no done_o is issued.

## Test plan
- Group 2 path with stall:
  - Stimulus: group=2, len_0=4, len_1=2, data_0=8'b11100100, data_1=6'b001001, out_ready constantly 1.
  - Required (grp,idx,node) sequence: (0,0,0), (0,1,1), (0,2,2), (0,3,3), (1,0,1), (1,1,2).
  - out_last_grp_o on entries 4 and 6. out_last_o only on entry 6. done_o one cycle later. count_o=6.
  - Rerun with out_ready low for 3 cycles at entry 2: outputs stable, same sequence.
- Group 3, clamping and skip:
  - Stimulus: group=3, len_0=7, len_1=0, len_2=2, data_0=8'hE4, data_2=4'b1001.
  - Required: nodes 0,1,2,3 from group 0 (L0 clamped to 4); group 1 skipped; (2,0,1), (2,1,2). count_o=6.
- Group limit masks lengths:
  - Stimulus: group=1, len_0=1, len_1=3, len_2=2, data_0=8'h03.
  - Required: single entry node 3 with out_last_o=1. count_o=1.
- Zero-length path:
  - Stimulus: group=0, start pulse.
  - Required: no out_valid_o, done_o high the cycle after start, busy_o high for 1 cycle.
- Busy protection:
  - Stimulus: start_i held high with changing data during EMIT.
  - Required: the stream matches the data latched at load. A start held high through DONE reloads exactly once, in the IDLE cycle.
- Reset mid-stream:
  - Stimulus: assert rst after 2 transfers.
  - Required: all outputs 0 at once (count_o=0, no done_o). A following start runs a full path normally.
